// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared CPU definitions for the multiply/divide unit.
//               Holds the MDOp encodings, the default latencies and the MDU
//               state encoding. The E-stage decoder uses the same encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // MDOp encodings (0 and 7 are "no operation")
  localparam logic [2:0] c_MD_MULT  = 3'd1;
  localparam logic [2:0] c_MD_MULTU = 3'd2;
  localparam logic [2:0] c_MD_DIV   = 3'd3;
  localparam logic [2:0] c_MD_DIVU  = 3'd4;
  localparam logic [2:0] c_MD_MTHI  = 3'd5;
  localparam logic [2:0] c_MD_MTLO  = 3'd6;

  // Default busy latencies
  localparam int c_MULT_CYCLES_DEF = 5;
  localparam int c_DIV_CYCLES_DEF  = 10;

  // MDU control states
  localparam logic c_ST_IDLE = 1'b0;
  localparam logic c_ST_RUN  = 1'b1;

  // True for the multi-cycle operations that make the unit busy
  function automatic logic isLongOp(input logic [2:0] op);
    return (op == c_MD_MULT) || (op == c_MD_MULTU) ||
           (op == c_MD_DIV)  || (op == c_MD_DIVU);
  endfunction

  // True for mult/multu
  function automatic logic isMulOp(input logic [2:0] op);
    return (op == c_MD_MULT) || (op == c_MD_MULTU);
  endfunction

  // True for the signed variants mult/div
  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == c_MD_MULT) || (op == c_MD_DIV);
  endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module      : mdu
// Description : Multiply/divide unit with architectural HI/LO registers.
//               Long operations latch their operands, stay busy for a fixed
//               number of cycles and commit HI/LO on the last busy edge.
//               The arithmetic itself is combinational from the latched
//               operands; the counter only models the pipeline latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = c_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = c_DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

  logic               r_state;
  logic               w_nextState;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] w_nextCount;

  logic [2:0]         r_op;
  logic [31:0]        r_opA;
  logic [31:0]        r_opB;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic               w_launch;
  logic               w_commit;
  logic               w_hiWe;
  logic               w_loWe;
  logic [31:0]        w_hiNext;
  logic [31:0]        w_loNext;

  logic               w_isMul;
  logic               w_isSigned;
  logic [63:0]        w_extA;
  logic [63:0]        w_extB;
  logic [63:0]        w_product;
  logic               w_negA;
  logic               w_negB;
  logic [31:0]        w_magA;
  logic [31:0]        w_magB;
  logic [31:0]        w_divisor;
  logic [31:0]        w_quotMag;
  logic [31:0]        w_remMag;
  logic [31:0]        w_quot;
  logic [31:0]        w_rem;

  // Start is only honoured when idle; a Start during Busy is dropped.
  assign w_launch = (r_state == c_ST_IDLE) && Start && isLongOp(MDOp);
  // Last busy cycle: the same edge leaves RUN and writes HI/LO.
  assign w_commit = (r_state == c_ST_RUN) && (r_count <= c_CNT_W'(1));

  // State and remaining-cycle counter register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= c_ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // Next-state and counter logic
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    case (r_state)
      c_ST_IDLE: begin
        if (w_launch) begin
          w_nextState = c_ST_RUN;
          w_nextCount = isMulOp(MDOp) ? c_CNT_W'(MULT_CYCLES) : c_CNT_W'(DIV_CYCLES);
        end
      end
      default: begin
        w_nextCount = r_count - c_CNT_W'(1);
        if (w_commit) begin
          w_nextState = c_ST_IDLE;
        end
      end
    endcase
  end

  // Operand and opcode capture at launch; held stable for the whole run
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_op  <= '0;
      r_opA <= '0;
      r_opB <= '0;
    end else if (w_launch) begin
      r_op  <= MDOp;
      r_opA <= A;
      r_opB <= B;
    end
  end

  // Arithmetic on the latched operands. The multiply extends both operands
  // to 64 bits (sign or zero) so one 64-bit product serves mult and multu.
  // The divide works on magnitudes and fixes the signs afterwards, which
  // gives truncation toward zero and a remainder signed like the dividend;
  // 0x80000000 / -1 falls out naturally as LO = 0x80000000, HI = 0.
  assign w_isMul    = isMulOp(r_op);
  assign w_isSigned = isSignedOp(r_op);
  assign w_extA     = {{32{w_isSigned & r_opA[31]}}, r_opA};
  assign w_extB     = {{32{w_isSigned & r_opB[31]}}, r_opB};
  assign w_product  = w_extA * w_extB;
  assign w_negA     = w_isSigned & r_opA[31];
  assign w_negB     = w_isSigned & r_opB[31];
  assign w_magA     = w_negA ? (~r_opA + 32'd1) : r_opA;
  assign w_magB     = w_negB ? (~r_opB + 32'd1) : r_opB;
  // A zero divisor never commits; substitute 1 to keep the divider defined.
  assign w_divisor  = (w_magB == 32'd0) ? 32'd1 : w_magB;
  assign w_quotMag  = w_magA / w_divisor;
  assign w_remMag   = w_magA % w_divisor;
  assign w_quot     = (w_negA ^ w_negB) ? (~w_quotMag + 32'd1) : w_quotMag;
  assign w_rem      = w_negA ? (~w_remMag + 32'd1) : w_remMag;

  // HI/LO write enables: long-op commit, or mthi/mtlo issued while idle
  always_comb begin
    w_hiWe   = 1'b0;
    w_loWe   = 1'b0;
    w_hiNext = r_hi;
    w_loNext = r_lo;
    if (w_commit) begin
      if (w_isMul) begin
        w_hiWe   = 1'b1;
        w_loWe   = 1'b1;
        w_hiNext = w_product[63:32];
        w_loNext = w_product[31:0];
      end else if (r_opB != 32'd0) begin
        w_hiWe   = 1'b1;
        w_loWe   = 1'b1;
        w_hiNext = w_rem;
        w_loNext = w_quot;
      end
    end else if ((r_state == c_ST_IDLE) && Start) begin
      if (MDOp == c_MD_MTHI) begin
        w_hiWe   = 1'b1;
        w_hiNext = A;
      end else if (MDOp == c_MD_MTLO) begin
        w_loWe   = 1'b1;
        w_loNext = A;
      end
    end
  end

  // Architectural HI/LO registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_hiWe) r_hi <= w_hiNext;
      if (w_loWe) r_lo <= w_loNext;
    end
  end

  assign HI   = r_hi;
  assign LO   = r_lo;
  assign Busy = (r_state == c_ST_RUN);

endmodule : mdu
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu
// Description : Self-checking bench for mdu. A transaction-level model
//               predicts HI/LO/Busy from the architectural rules (result
//               computed with plain integer arithmetic, committed a fixed
//               number of cycles after acceptance); one process compares
//               every cycle, and directed cases pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  mdu #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .MDOp (MDOp),
    .Start(Start),
    .A    (A),
    .B    (B),
    .HI   (HI),
    .LO   (LO),
    .Busy (Busy)
  );

  always #5 Clk = ~Clk;

  // Single comparison point
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  bit          pending = 1'b0;
  logic [31:0] pHi, pLo;
  bit          pWrite;
  longint      commitCyc = 0;
  longint      cyc = 0;

  function automatic void refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo, output bit wr);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1;
    hi = '0;
    lo = '0;
    case (op)
      3'd1: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'd3: begin
        if (b == 0) wr = 1'b0;
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      default: begin
        if (b == 0) wr = 1'b0;
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  // Model advances on each rising edge using the inputs presented for it
  initial begin
    bit wasBusy;
    forever begin
      @(posedge Clk);
      cyc++;
      if (Reset) begin
        mHi = '0;
        mLo = '0;
        pending = 1'b0;
      end else begin
        wasBusy = pending;
        if (pending && cyc == commitCyc) begin
          if (pWrite) begin
            mHi = pHi;
            mLo = pLo;
          end
          pending = 1'b0;
        end
        if (!wasBusy && Start) begin
          if (MDOp >= 3'd1 && MDOp <= 3'd4) begin
            refResult(MDOp, A, B, pHi, pLo, pWrite);
            pending   = 1'b1;
            commitCyc = cyc + ((MDOp <= 3'd2) ? MULT_N : DIV_N);
          end else if (MDOp == 3'd5) begin
            mHi = A;
          end else if (MDOp == 3'd6) begin
            mLo = A;
          end
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge
  initial begin
    forever begin
      @(negedge Clk);
      if (checkEn) begin
        check("cycle Busy", {31'b0, Busy}, {31'b0, pending});
        check("cycle HI", HI, mHi);
        check("cycle LO", LO, mLo);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Issue one op (called at a falling edge), then count busy cycles (bounded)
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    @(negedge Clk);
    Start = 1'b0;
    MDOp  = 3'd0;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      n++;
      @(negedge Clk);
    end
  endtask

  function automatic logic [31:0] pick(input bit zeroBias);
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return zeroBias ? 32'h0 : 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    Reset = 1'b1;
    Start = 1'b0;
    MDOp  = 3'd0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge Clk);
    check("reset HI", HI, 32'h0);
    check("reset LO", LO, 32'h0);
    check("reset Busy", {31'b0, Busy}, 32'h0);
    Reset   = 1'b0;
    checkEn = 1'b1;

    // signed multiply: -2 * 3 = -6
    runOp(3'd1, 32'hFFFF_FFFE, 32'd3, n);
    check("mult busy cycles", n, 32'd5);
    check("mult HI", HI, 32'hFFFF_FFFF);
    check("mult LO", LO, 32'hFFFF_FFFA);

    // unsigned multiply: (2^32-1)^2
    runOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu busy cycles", n, 32'd5);
    check("multu HI", HI, 32'hFFFF_FFFE);
    check("multu LO", LO, 32'h0000_0001);

    // signed divide -7 / 2 = -3 rem -1
    runOp(3'd3, 32'hFFFF_FFF9, 32'd2, n);
    check("div busy cycles", n, 32'd10);
    check("div LO", LO, 32'hFFFF_FFFD);
    check("div HI", HI, 32'hFFFF_FFFF);

    // unsigned divide of the same operands
    runOp(3'd4, 32'hFFFF_FFF9, 32'd2, n);
    check("divu busy cycles", n, 32'd10);
    check("divu LO", LO, 32'h7FFF_FFFC);
    check("divu HI", HI, 32'h0000_0001);

    // divide by zero leaves HI/LO alone
    runOp(3'd5, 32'h11, 32'h0, n);
    check("mthi busy cycles", n, 32'd0);
    runOp(3'd6, 32'h22, 32'h0, n);
    runOp(3'd3, 32'd5, 32'd0, n);
    check("div0 busy cycles", n, 32'd10);
    check("div0 HI", HI, 32'h11);
    check("div0 LO", LO, 32'h22);

    // signed overflow case
    runOp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divovf LO", LO, 32'h8000_0000);
    check("divovf HI", HI, 32'h0);

    // mtlo writes next cycle without going busy
    runOp(3'd6, 32'h1234, 32'h0, n);
    check("mtlo busy cycles", n, 32'd0);
    check("mtlo LO", LO, 32'h1234);

    // mthi during Busy is ignored
    runOp(3'd5, 32'h55, 32'h0, n);
    Start = 1'b1; MDOp = 3'd1; A = 32'd7; B = 32'd6;
    @(negedge Clk);
    Start = 1'b1; MDOp = 3'd5; A = 32'hDEAD;
    @(negedge Clk);
    Start = 1'b0; MDOp = 3'd0;
    check("mthi-in-busy HI", HI, 32'h55);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin n++; @(negedge Clk); end
    check("mult after ignored mthi HI", HI, 32'h0);
    check("mult after ignored mthi LO", LO, 32'd42);

    // Start accepted on the cycle Busy falls
    runOp(3'd1, 32'd3, 32'd4, n);
    check("b2b first LO", LO, 32'd12);
    runOp(3'd4, 32'd100, 32'd7, n);
    check("b2b second busy cycles", n, 32'd10);
    check("b2b second LO", LO, 32'd14);
    check("b2b second HI", HI, 32'd2);

    // Reset on the 3rd busy cycle of a mult aborts it
    runOp(3'd5, 32'h77, 32'h0, n);
    Start = 1'b1; MDOp = 3'd1; A = 32'd2; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0; MDOp = 3'd0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort Busy", {31'b0, Busy}, 32'h0);
    check("abort HI", HI, 32'h0);
    check("abort LO", LO, 32'h0);
    repeat (6) @(negedge Clk);
    check("abort LO later", LO, 32'h0);

    // Reset wins over a simultaneous Start
    runOp(3'd6, 32'h99, 32'h0, n);
    Reset = 1'b1; Start = 1'b1; MDOp = 3'd1; A = 32'd5; B = 32'd5;
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0; MDOp = 3'd0;
    check("reset+start Busy", {31'b0, Busy}, 32'h0);
    check("reset+start LO", LO, 32'h0);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 800; i++) begin
      Reset = ($urandom_range(0, 199) == 0);
      Start = ($urandom_range(0, 2) == 0);
      MDOp  = 3'($urandom_range(0, 7));
      A     = pick(1'b0);
      B     = pick(1'b1);
      @(negedge Clk);
    end
    Reset = 1'b0;
    Start = 1'b0;
    MDOp  = 3'd0;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin n++; @(negedge Clk); end
    check("final idle", {31'b0, Busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Hard stop if the bench ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mdu
`default_nettype wire
